// File: rtl/wb_cam_capture.sv
// Wishbone-attached parallel camera capture block.
// The camera pins are synchronised into clk; a small FSM gates whole frames
// into a pixel FIFO that the host drains through the DATA register.
module wb_cam_capture #(
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_ADR_WIDTH = 32,
  parameter int PIX_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int XCLK_DIV     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    xclk,
  input  logic                    pclk,
  input  logic                    href,
  input  logic                    vsync,
  input  logic [PIX_WIDTH-1:0]    din,
  input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_sel_i,
  output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int XW = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_FCNT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS,
    S_CAPTURE
  } state_t;

  state_t state, state_nxt;

  // Only the register-select bits, the low data bits and none of the byte
  // selects matter; fold the rest together so they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i, wb_dat_i};

  // ---------------------------------------------------------------------
  // Camera master clock
  // ---------------------------------------------------------------------
  logic [XW-1:0] xclk_cnt;

  // Free-running divider: toggle xclk every XCLK_DIV clk cycles.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      xclk_cnt <= '0;
      xclk     <= 1'b0;
    end else if (xclk_cnt == XW'(XCLK_DIV - 1)) begin
      xclk_cnt <= '0;
      xclk     <= ~xclk;
    end else begin
      xclk_cnt <= xclk_cnt + XW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic                 pclk_m, pclk_s, pclk_d;
  logic                 href_m, href_s;
  logic                 vsync_m, vsync_s, vsync_d;
  logic [PIX_WIDTH-1:0] din_m, din_s;

  // Two-flop synchronisers plus one history flop for pclk/vsync edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_m  <= 1'b0;
      pclk_s  <= 1'b0;
      pclk_d  <= 1'b0;
      href_m  <= 1'b0;
      href_s  <= 1'b0;
      vsync_m <= 1'b0;
      vsync_s <= 1'b0;
      vsync_d <= 1'b0;
      din_m   <= '0;
      din_s   <= '0;
    end else begin
      pclk_m  <= pclk;
      pclk_s  <= pclk_m;
      pclk_d  <= pclk_s;
      href_m  <= href;
      href_s  <= href_m;
      vsync_m <= vsync;
      vsync_s <= vsync_m;
      vsync_d <= vsync_s;
      din_m   <= din;
      din_s   <= din_m;
    end
  end

  logic pclk_rise, vs_rise, vs_fall;
  assign pclk_rise = pclk_s & ~pclk_d;
  assign vs_rise   = vsync_s & ~vsync_d;
  assign vs_fall   = ~vsync_s & vsync_d;

  // ---------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------
  logic       access, bus_wr, bus_rd, data_rd, flush;
  logic [1:0] reg_sel;

  assign access  = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign reg_sel = wb_adr_i[3:2];
  assign bus_wr  = access & wb_we_i;
  assign bus_rd  = access & ~wb_we_i;
  assign data_rd = bus_rd & (reg_sel == REG_DATA);
  assign flush   = bus_wr & (reg_sel == REG_CTRL) & wb_dat_i[2];

  // ---------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------
  logic        ctrl_en, ctrl_single, irq_en;
  logic        overflow, frame_done;
  logic [15:0] frame_cnt;
  logic        cap_push, frame_end;

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, pixel push request and end-of-frame pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt = state;
    cap_push  = 1'b0;
    frame_end = 1'b0;
    if (!ctrl_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_WAIT_VS;
        // Only a vsync fall starts a frame, so one already running when
        // capture is enabled is never picked up half-way.
        S_WAIT_VS: if (vs_fall) state_nxt = S_CAPTURE;
        S_CAPTURE: begin
          cap_push = pclk_rise & href_s;
          if (vs_rise) begin
            frame_end = 1'b1;
            state_nxt = ctrl_single ? S_IDLE : S_WAIT_VS;
          end
        end
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Pixel FIFO (extra pointer bit distinguishes full from empty)
  // ---------------------------------------------------------------------
  logic [PIX_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0]        wr_ptr, rd_ptr, level;
  logic                 empty, full, pop, push_req, push_ok, ovf_set;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == LW'(FIFO_DEPTH));
  assign pop      = data_rd & ~empty;
  // A flush wins over a push landing in the same cycle.
  assign push_req = cap_push & ~flush;
  // When full, a simultaneous pop frees the slot the push writes into.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  // Pointer update; flush collapses both pointers to zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LW'(1);
      if (pop)     rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // Pixel storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define
    // which entries are valid, so clearing the array would buy nothing.
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din_s;
  end

  // Register writes; hardware events are applied last so they take
  // priority over a same-cycle host write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en     <= 1'b0;
      ctrl_single <= 1'b0;
      irq_en      <= 1'b0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (bus_wr) begin
        case (reg_sel)
          REG_CTRL: begin
            ctrl_en     <= wb_dat_i[0];
            ctrl_single <= wb_dat_i[1];
          end
          REG_STATUS: begin
            if (wb_dat_i[2]) overflow   <= 1'b0;
            if (wb_dat_i[3]) frame_done <= 1'b0;
            irq_en <= wb_dat_i[5];
          end
          REG_FCNT: frame_cnt <= '0;
          default: ;
        endcase
      end
      if (ovf_set) overflow <= 1'b1;
      if (frame_end) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
        if (ctrl_single) ctrl_en <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read mux and bus response
  // ---------------------------------------------------------------------
  logic [WB_DAT_WIDTH-1:0] rd_data;

  // Read data for the register being addressed this cycle.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data[0] = ctrl_en;
        rd_data[1] = ctrl_single;
      end
      REG_DATA: if (!empty) rd_data[PIX_WIDTH-1:0] = mem[rd_ptr[AW-1:0]];
      REG_STATUS: begin
        rd_data[0]    = empty;
        rd_data[1]    = full;
        rd_data[2]    = overflow;
        rd_data[3]    = frame_done;
        rd_data[4]    = (state == S_CAPTURE);
        rd_data[5]    = irq_en;
        rd_data[15:8] = 8'(level);
      end
      REG_FCNT: rd_data[15:0] = frame_cnt;
      default: ;
    endcase
  end

  // Single-cycle ack one cycle after the access, read data alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= bus_rd ? rd_data : '0;
    end
  end

  // Registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= irq_en & (frame_done | overflow);
  end

endmodule
